// File: rtl/tile_buffer_bank.sv
// Multi-buffer tile store: BUFFER_COUNT buffers of up to MAX_TILES tiles each,
// valid/ready write and read streams with read-after-write protection and wrap-around re-reads.
module tile_buffer_bank #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int TILE_SIZE    = 32,
  parameter  int MAX_TILES    = 32,
  parameter  int BUFFER_COUNT = 4,
  localparam int TILE_WIDTH   = DATA_WIDTH * TILE_SIZE,
  localparam int BW           = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1,
  localparam int CW           = $clog2(MAX_TILES) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  input  logic [BW-1:0]           cfg_buffer,
  input  logic [CW-1:0]           cfg_tiles,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [BW-1:0]           wr_buffer,
  input  logic [TILE_WIDTH-1:0]   wr_data,
  output logic                    wr_done,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [BW-1:0]           rd_buffer,
  output logic                    rd_data_valid,
  output logic [TILE_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic [BUFFER_COUNT-1:0] buf_full
);

  localparam int DEPTH = BUFFER_COUNT * MAX_TILES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] len  [BUFFER_COUNT];
  logic [CW-1:0] wcnt [BUFFER_COUNT];
  logic [CW-1:0] ridx [BUFFER_COUNT];

  logic [TILE_WIDTH-1:0] mem [DEPTH];

  logic          wr_fire;
  logic          rd_fire;
  logic          rd_wrap;
  logic [CW-1:0] cfg_len;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Handshakes look only at registered counters, so a tile written this cycle
  // is not readable until the next one.
  assign wr_ready = (wcnt[wr_buffer] < len[wr_buffer]) &&
                    !(cfg_valid && (cfg_buffer == wr_buffer));
  assign rd_ready = (ridx[rd_buffer] < wcnt[rd_buffer]) &&
                    !(cfg_valid && (cfg_buffer == rd_buffer));
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;
  assign rd_wrap  = (ridx[rd_buffer] == (len[rd_buffer] - CW'(1)));

  assign cfg_len  = ((cfg_tiles == '0) || (cfg_tiles > CW'(MAX_TILES))) ?
                    CW'(MAX_TILES) : cfg_tiles;

  assign wr_addr  = AW'(wr_buffer) * AW'(MAX_TILES) + AW'(wcnt[wr_buffer]);
  assign rd_addr  = AW'(rd_buffer) * AW'(MAX_TILES) + AW'(ridx[rd_buffer]);

  always_comb begin
    buf_full = '0;
    for (int unsigned b = 0; b < BUFFER_COUNT; b++) begin
      buf_full[b] = (wcnt[b] == len[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < BUFFER_COUNT; b++) begin
        len[b]  <= CW'(MAX_TILES);
        wcnt[b] <= '0;
        ridx[b] <= '0;
      end
      wr_done       <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_last       <= 1'b0;
      rd_data       <= '0;
    end else begin
      wr_done       <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_last       <= 1'b0;

      if (wr_fire) begin
        wcnt[wr_buffer] <= wcnt[wr_buffer] + CW'(1);
        wr_done         <= ((wcnt[wr_buffer] + CW'(1)) == len[wr_buffer]);
      end

      if (rd_fire) begin
        rd_data         <= mem[rd_addr];
        rd_data_valid   <= 1'b1;
        rd_last         <= rd_wrap;
        ridx[rd_buffer] <= rd_wrap ? '0 : ridx[rd_buffer] + CW'(1);
      end

      // Fires on the configured buffer are already blocked by the handshakes.
      if (cfg_valid) begin
        len[cfg_buffer]  <= cfg_len;
        wcnt[cfg_buffer] <= '0;
        ridx[cfg_buffer] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_buffer_bank.sv
// Randomized and directed bench for tile_buffer_bank against a per-buffer
// tile-array reference model.
module tb_tile_buffer_bank;

  localparam int DW = 8;
  localparam int TS = 32;
  localparam int MT = 32;
  localparam int BC = 4;
  localparam int TW = DW * TS;
  localparam int BW = 2;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic [BW-1:0] cfg_buffer;
  logic [CW-1:0] cfg_tiles;
  logic          wr_valid;
  logic          wr_ready;
  logic [BW-1:0] wr_buffer;
  logic [TW-1:0] wr_data;
  logic          wr_done;
  logic          rd_valid;
  logic          rd_ready;
  logic [BW-1:0] rd_buffer;
  logic          rd_data_valid;
  logic [TW-1:0] rd_data;
  logic          rd_last;
  logic [BC-1:0] buf_full;

  tile_buffer_bank #(
    .DATA_WIDTH  (DW),
    .TILE_SIZE   (TS),
    .MAX_TILES   (MT),
    .BUFFER_COUNT(BC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_buffer   (cfg_buffer),
    .cfg_tiles    (cfg_tiles),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_buffer    (wr_buffer),
    .wr_data      (wr_data),
    .wr_done      (wr_done),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_buffer    (rd_buffer),
    .rd_data_valid(rd_data_valid),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .buf_full     (buf_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each buffer is an array of tiles plus fill/read positions.
  int            m_len  [BC];
  int            m_fill [BC];
  int            m_rpos [BC];
  logic [TW-1:0] m_tile [BC][MT];
  logic [TW-1:0] m_rdata;
  logic          m_rvalid;
  logic          m_rlast;
  logic          m_done;
  int            done_seen;

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_tile(input int t);
    logic [TW-1:0] v;
    for (int i = 0; i < TS; i++) v[i*DW +: DW] = DW'(t * TS + i);
    return v;
  endfunction

  function automatic logic [TW-1:0] rnd_tile();
    logic [TW-1:0] v;
    for (int i = 0; i < TW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock: drive, check readies mid-cycle, advance model, check registered outputs.
  task automatic cycle(input bit rst, input bit cv, input int cb, input int ct,
                       input bit wv, input int wb, input logic [TW-1:0] wd,
                       input bit rv, input int rb);
    bit   exp_wr, exp_rd;
    logic [BC-1:0] exp_full;
    reset      = rst;
    cfg_valid  = cv;
    cfg_buffer = BW'(cb);
    cfg_tiles  = CW'(ct);
    wr_valid   = wv;
    wr_buffer  = BW'(wb);
    wr_data    = wd;
    rd_valid   = rv;
    rd_buffer  = BW'(rb);
    #3;
    exp_wr = (m_fill[wb] < m_len[wb]) && !(cv && cb == wb);
    exp_rd = (m_rpos[rb] < m_fill[rb]) && !(cv && cb == rb);
    if (!rst) begin
      check("wr_ready", TW'(wr_ready), TW'(exp_wr));
      check("rd_ready", TW'(rd_ready), TW'(exp_rd));
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_done   = 1'b0;
    if (rst) begin
      for (int b = 0; b < BC; b++) begin
        m_len[b] = MT; m_fill[b] = 0; m_rpos[b] = 0;
      end
      m_rdata = '0;
    end else begin
      if (rv && exp_rd) begin
        m_rdata  = m_tile[rb][m_rpos[rb]];
        m_rvalid = 1'b1;
        m_rlast  = (m_rpos[rb] == m_len[rb] - 1);
        m_rpos[rb] = (m_rpos[rb] + 1) % m_len[rb];
      end
      if (wv && exp_wr) begin
        m_tile[wb][m_fill[wb]] = wd;
        m_fill[wb]++;
        m_done = (m_fill[wb] == m_len[wb]);
      end
      if (cv) begin
        m_len[cb]  = (ct == 0 || ct > MT) ? MT : ct;
        m_fill[cb] = 0;
        m_rpos[cb] = 0;
      end
    end
    for (int b = 0; b < BC; b++) exp_full[b] = (m_fill[b] == m_len[b]);
    @(posedge clk);
    #1;
    if (wr_done === 1'b1) done_seen++;
    check("wr_done",       TW'(wr_done),       TW'(m_done));
    check("rd_data_valid", TW'(rd_data_valid), TW'(m_rvalid));
    check("rd_last",       TW'(rd_last),       TW'(m_rlast));
    check("rd_data",       rd_data,            m_rdata);
    check("buf_full",      TW'(buf_full),      TW'(exp_full));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 0; cfg_buffer = '0; cfg_tiles = '0;
    wr_valid = 0; wr_buffer = '0; wr_data = '0; rd_valid = 0; rd_buffer = '0;
    done_seen = 0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 0, 0, '0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, '0, 0, 0);

    // 1: fill b0 with four tiles, then a fifth write stalls
    cycle(0, 1, 0, 4, 0, 0, '0, 0, 0);
    for (int t = 0; t < 4; t++) cycle(0, 0, 0, 0, 1, 0, mk_tile(t), 0, 0);
    check("s1_buf_full", TW'(buf_full), TW'(4'b0001));
    cycle(0, 0, 0, 0, 1, 0, mk_tile(4), 0, 0);

    // 2: eight back-to-back reads wrap around b0
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0, 0, 0, '0, 1, 0);
    idle();

    // 3: read-after-write protection on b1
    cycle(0, 1, 1, 3, 0, 0, '0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, '0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1, mk_tile(10), 0, 0);
    cycle(0, 0, 0, 0, 0, 0, '0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1, mk_tile(11), 1, 1);
    cycle(0, 0, 0, 0, 0, 0, '0, 1, 1);

    // 4: length clamping to MAX_TILES
    for (int pass = 0; pass < 2; pass++) begin
      cycle(0, 1, 2, (pass == 0) ? 0 : MT + 5, 0, 0, '0, 0, 0);
      done_seen = 0;
      for (int t = 0; t < MT + 1; t++) cycle(0, 0, 0, 0, 1, 2, rnd_tile(), 0, 0);
      check("s4_wr_done_once", TW'(done_seen), TW'(1));
    end

    // 5: cfg on b2 blocks both streams there; b3 write unaffected
    cycle(0, 1, 2, 2, 1, 2, rnd_tile(), 1, 2);
    cycle(0, 1, 2, 2, 1, 3, rnd_tile(), 1, 2);
    cycle(0, 0, 0, 0, 0, 0, '0, 1, 3);

    // 6: reset right after a read accept on b0
    cycle(0, 0, 0, 0, 0, 0, '0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, '0, 0, 0);
    check("s6_buf_full", TW'(buf_full), TW'(4'b0000));
    cycle(0, 0, 0, 0, 0, 0, '0, 1, 0);

    // Randomized traffic with mostly short lengths so wraps happen often
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 15) == 0), $urandom_range(0, BC - 1),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(1, 6),
            ($urandom_range(0, 1) == 1), $urandom_range(0, BC - 1), rnd_tile(),
            ($urandom_range(0, 3) != 0), $urandom_range(0, BC - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
